// File: rtl/score_board.sv
// Register scoreboard for a dual-issue in-order pipeline: tracks where each
// register's pending producer sits (execute/memory/commit) for the bypass network.
package score_board_pkg;
  localparam int unsigned REG_ADDR  = 5;
  localparam int unsigned NUM_REGS  = 32;
  localparam int unsigned NUM_LANES = 2;
  localparam int unsigned NUM_SRCS  = 4;
  localparam int unsigned POS_W     = 3;

  typedef struct packed {
    logic [POS_W-1:0] position;
    logic             line;
  } sb_data_t;
endpackage

module score_board
  import score_board_pkg::*;
(
  input  logic                                 clk,
  input  logic                                 resetn,
  input  logic                                 advance,
  input  logic                                 flush,
  input  logic [NUM_LANES-1:0]                 issue_valid,
  input  logic [NUM_LANES-1:0][REG_ADDR-1:0]   issue_dest,
  input  logic [NUM_LANES-1:0]                 issue_is_load,
  input  logic [NUM_SRCS-1:0][REG_ADDR-1:0]    src_addr,
  output sb_data_t [NUM_SRCS-1:0]              score_board_data,
  output logic [NUM_SRCS-1:0]                  src_ready,
  output logic                                 load_use_stall
);

  logic [NUM_REGS-1:0]            valid_q, valid_d;
  logic [NUM_REGS-1:0][POS_W-1:0] pos_q,   pos_d;
  logic [NUM_REGS-1:0]            line_q,  line_d;
  logic [NUM_REGS-1:0]            load_q,  load_d;

  // Next state: flush beats everything, then shift, then issue overwrites (lane 1 last so it wins).
  always_comb begin
    valid_d = valid_q;
    pos_d   = pos_q;
    line_d  = line_q;
    load_d  = load_q;
    if (flush) begin
      valid_d = '0;
      pos_d   = '0;
      line_d  = '0;
      load_d  = '0;
    end else if (advance) begin
      for (int r = 1; r < NUM_REGS; r++) begin
        pos_d[r]   = {1'b0, pos_q[r][POS_W-1:1]};
        valid_d[r] = valid_q[r] & (|pos_q[r][POS_W-1:1]);
        if (!valid_d[r]) begin
          pos_d[r]  = '0;
          line_d[r] = 1'b0;
          load_d[r] = 1'b0;
        end
      end
      for (int l = 0; l < NUM_LANES; l++) begin
        if (issue_valid[l] && (issue_dest[l] != '0)) begin
          valid_d[issue_dest[l]] = 1'b1;
          pos_d[issue_dest[l]]   = 3'b100;
          line_d[issue_dest[l]]  = 1'(l);
          load_d[issue_dest[l]]  = issue_is_load[l];
        end
      end
    end
    // Register 0 is hardwired: never tracked.
    valid_d[0] = 1'b0;
    pos_d[0]   = '0;
    line_d[0]  = 1'b0;
    load_d[0]  = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= '0;
      pos_q   <= '0;
      line_q  <= '0;
      load_q  <= '0;
    end else begin
      valid_q <= valid_d;
      pos_q   <= pos_d;
      line_q  <= line_d;
      load_q  <= load_d;
    end
  end

  // Combinational lookup on registered state only.
  always_comb begin
    for (int k = 0; k < NUM_SRCS; k++) begin
      score_board_data[k].position = valid_q[src_addr[k]] ? pos_q[src_addr[k]] : 3'b000;
      score_board_data[k].line     = valid_q[src_addr[k]] & line_q[src_addr[k]];
      src_ready[k] = ~(valid_q[src_addr[k]] & pos_q[src_addr[k]][POS_W-1] & load_q[src_addr[k]]);
    end
  end

  assign load_use_stall = (issue_valid[0] & ~(src_ready[0] & src_ready[1])) |
                          (issue_valid[1] & ~(src_ready[2] & src_ready[3]));

endmodule

// File: tb/tb_score_board.sv
// Self-checking bench for score_board: directed vector table plus random
// stimulus against a stage-countdown reference model.
module tb_score_board;
  import score_board_pkg::*;

  logic                  clk = 1'b0;
  logic                  resetn;
  logic                  advance;
  logic                  flush;
  logic [1:0]            issue_valid;
  logic [1:0][4:0]       issue_dest;
  logic [1:0]            issue_is_load;
  logic [3:0][4:0]       src_addr;
  sb_data_t [3:0]        sbd;
  logic [3:0]            src_ready;
  logic                  load_use_stall;

  int errors = 0;
  int checks = 0;

  score_board dut (
    .clk(clk), .resetn(resetn), .advance(advance), .flush(flush),
    .issue_valid(issue_valid), .issue_dest(issue_dest), .issue_is_load(issue_is_load),
    .src_addr(src_addr), .score_board_data(sbd), .src_ready(src_ready),
    .load_use_stall(load_use_stall)
  );

  always #5 clk = ~clk;

  // Reference model: cycles left before the value reaches the register file.
  int rem   [32];
  bit mline [32];
  bit mload [32];

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int r = 0; r < 32; r++) begin rem[r] = 0; mline[r] = 0; mload[r] = 0; end
    end else if (flush) begin
      for (int r = 0; r < 32; r++) rem[r] = 0;
    end else if (advance) begin
      for (int r = 0; r < 32; r++) if (rem[r] > 0) rem[r] = rem[r] - 1;
      for (int l = 0; l < 2; l++)
        if (issue_valid[l] && issue_dest[l] != 0) begin
          rem[issue_dest[l]]   = 3;
          mline[issue_dest[l]] = (l == 1);
          mload[issue_dest[l]] = issue_is_load[l];
        end
    end
  end

  function automatic logic [2:0] m_pos(input int r);
    case (rem[r])
      3: return 3'b100;
      2: return 3'b010;
      1: return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic m_rdy(input int r);
    return !(rem[r] == 3 && mload[r]);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    logic [3:0] er;
    for (int k = 0; k < 4; k++) begin
      er[k] = m_rdy(int'(src_addr[k]));
      check($sformatf("%s pos[%0d]", tag, k), 32'(sbd[k].position), 32'(m_pos(int'(src_addr[k]))));
      check($sformatf("%s line[%0d]", tag, k), 32'(sbd[k].line),
            32'(rem[src_addr[k]] > 0 ? mline[src_addr[k]] : 1'b0));
      check($sformatf("%s rdy[%0d]", tag, k), 32'(src_ready[k]), 32'(er[k]));
    end
    check($sformatf("%s stall", tag), 32'(load_use_stall),
          32'((issue_valid[0] & ~(er[0] & er[1])) | (issue_valid[1] & ~(er[2] & er[3]))));
  endtask

  typedef struct {
    logic       adv;
    logic       fl;
    logic [1:0] iv;
    logic [4:0] d0;
    logic [4:0] d1;
    logic [1:0] ld;
    logic [4:0] s0;
    logic [2:0] e_pos;
    logic       e_line;
    logic       e_rdy;
    logic       e_stall;
  } vec_t;

  vec_t vecs [25];

  task automatic idle_inputs();
    advance = 1'b0; flush = 1'b0; issue_valid = '0; issue_dest = '0;
    issue_is_load = '0; src_addr = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    // Inputs are applied, outputs checked before the edge, then the edge acts on the inputs.
    //          adv   fl    iv     d0     d1     ld     s0     pos     ln    rdy   stall
    vecs[0]  = '{1'b1, 1'b0, 2'b01, 5'd5,  5'd0,  2'b00, 5'd5,  3'b000, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 2'b00, 5'd0,  5'd0,  2'b00, 5'd5,  3'b100, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 2'b00, 5'd0,  5'd0,  2'b00, 5'd5,  3'b010, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 2'b00, 5'd0,  5'd0,  2'b00, 5'd5,  3'b001, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 2'b00, 5'd0,  5'd0,  2'b00, 5'd5,  3'b000, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 2'b11, 5'd7,  5'd7,  2'b00, 5'd7,  3'b000, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 2'b00, 5'd0,  5'd0,  2'b00, 5'd7,  3'b100, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 2'b01, 5'd3,  5'd0,  2'b00, 5'd3,  3'b000, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 2'b01, 5'd3,  5'd0,  2'b00, 5'd3,  3'b100, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 2'b00, 5'd0,  5'd0,  2'b00, 5'd3,  3'b100, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 2'b10, 5'd0,  5'd9,  2'b10, 5'd9,  3'b000, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 2'b01, 5'd12, 5'd0,  2'b00, 5'd9,  3'b100, 1'b1, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 2'b01, 5'd12, 5'd0,  2'b00, 5'd9,  3'b100, 1'b1, 1'b0, 1'b1};
    vecs[13] = '{1'b1, 1'b0, 2'b00, 5'd0,  5'd0,  2'b00, 5'd9,  3'b100, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 2'b00, 5'd0,  5'd0,  2'b00, 5'd9,  3'b010, 1'b1, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 2'b00, 5'd0,  5'd0,  2'b00, 5'd12, 3'b000, 1'b0, 1'b1, 1'b0};
    vecs[16] = '{1'b1, 1'b0, 2'b01, 5'd20, 5'd0,  2'b00, 5'd20, 3'b000, 1'b0, 1'b1, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 2'b01, 5'd21, 5'd0,  2'b00, 5'd20, 3'b100, 1'b0, 1'b1, 1'b0};
    vecs[18] = '{1'b1, 1'b0, 2'b01, 5'd22, 5'd0,  2'b00, 5'd20, 3'b010, 1'b0, 1'b1, 1'b0};
    vecs[19] = '{1'b1, 1'b1, 2'b11, 5'd23, 5'd24, 2'b00, 5'd20, 3'b001, 1'b0, 1'b1, 1'b0};
    vecs[20] = '{1'b0, 1'b0, 2'b00, 5'd0,  5'd0,  2'b00, 5'd20, 3'b000, 1'b0, 1'b1, 1'b0};
    vecs[21] = '{1'b0, 1'b0, 2'b00, 5'd0,  5'd0,  2'b00, 5'd22, 3'b000, 1'b0, 1'b1, 1'b0};
    vecs[22] = '{1'b0, 1'b0, 2'b00, 5'd0,  5'd0,  2'b00, 5'd24, 3'b000, 1'b0, 1'b1, 1'b0};
    vecs[23] = '{1'b1, 1'b0, 2'b11, 5'd0,  5'd0,  2'b11, 5'd0,  3'b000, 1'b0, 1'b1, 1'b0};
    vecs[24] = '{1'b0, 1'b0, 2'b00, 5'd0,  5'd0,  2'b00, 5'd0,  3'b000, 1'b0, 1'b1, 1'b0};

    idle_inputs();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    src_addr[0] = 5'd5; src_addr[1] = 5'd9; src_addr[2] = 5'd31; src_addr[3] = 5'd0;
    #1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("reset data[%0d]", k), 32'(sbd[k]), 32'd0);
      check($sformatf("reset rdy[%0d]", k), 32'(src_ready[k]), 32'd1);
    end
    check("reset stall", 32'(load_use_stall), 32'd0);
    resetn = 1'b1;

    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      advance = vecs[i].adv; flush = vecs[i].fl; issue_valid = vecs[i].iv;
      issue_dest[0] = vecs[i].d0; issue_dest[1] = vecs[i].d1;
      issue_is_load = vecs[i].ld; src_addr = '0; src_addr[0] = vecs[i].s0;
      #1;
      check($sformatf("vec%0d pos", i), 32'(sbd[0].position), 32'(vecs[i].e_pos));
      check($sformatf("vec%0d line", i), 32'(sbd[0].line), 32'(vecs[i].e_line));
      check($sformatf("vec%0d rdy", i), 32'(src_ready[0]), 32'(vecs[i].e_rdy));
      check($sformatf("vec%0d stall", i), 32'(load_use_stall), 32'(vecs[i].e_stall));
    end

    do_reset();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      advance       = ($urandom_range(0, 3) != 0);
      flush         = ($urandom_range(0, 24) == 0);
      issue_valid   = 2'($urandom_range(0, 3));
      issue_dest[0] = 5'($urandom_range(0, 7));
      issue_dest[1] = 5'($urandom_range(0, 7));
      issue_is_load = 2'($urandom_range(0, 3));
      for (int k = 0; k < 4; k++) src_addr[k] = 5'($urandom_range(0, 7));
      #1;
      check_model($sformatf("rnd%0d", i));
    end

    // Asynchronous reset mid-cycle with live producers.
    do_reset();
    @(negedge clk);
    advance = 1'b1; issue_valid = 2'b11; issue_dest[0] = 5'd5; issue_dest[1] = 5'd6;
    issue_is_load = 2'b10;
    @(negedge clk);
    issue_valid = 2'b01; issue_dest[0] = 5'd8; issue_is_load = 2'b00;
    @(negedge clk);
    idle_inputs();
    src_addr[0] = 5'd5; src_addr[1] = 5'd6; src_addr[2] = 5'd8; src_addr[3] = 5'd6;
    #1;
    check_model("pre-areset");
    check("pre-areset live", 32'(sbd[2].position), 32'(3'b100));
    #1;
    resetn = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("areset data[%0d]", k), 32'(sbd[k]), 32'd0);
      check($sformatf("areset rdy[%0d]", k), 32'(src_ready[k]), 32'd1);
    end
    check("areset stall", 32'(load_use_stall), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    advance = 1'b1;
    #1;
    check_model("post-areset");
    check("post-areset empty", 32'(sbd[2].position), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/score_board.md
SCORE_BOARD -- requirements
Module: score_board

Interface
- REQ-001: The block SHALL have one clock and an asynchronous, active-low reset: one clock; reset is asynchronous and active-low.
- REQ-002: clk  input  1  pipeline clock; all state updates on rising edge.
- REQ-003: resetn  input  1  asynchronous active-low reset.
- REQ-004: advance  input  1  pipeline moves one stage this cycle; 0 = global stall.
- REQ-005: flush  input  1  squash all in-flight execute/memory instructions.
- REQ-006: issue_valid  input  [1:0]  lane i issues a register-writing instruction this cycle.
- REQ-007: issue_dest  input  [1:0] x REG_ADDR (5)  destination register per lane.
- REQ-008: issue_is_load  input  [1:0]  lane i is a load (result not available in execute).
- REQ-009: src_addr  input  [3:0] x REG_ADDR (5)  source operands: lane0 rs/rt = 0/1, lane1 rs/rt = 2/3.
- REQ-010: score_board_data  output  [3:0] x SCORE_BOARD_DATA  per source {position[2:0], line}, consumed by the bypass network.
- REQ-011: src_ready  output  [3:0]  source value obtainable this cycle (regfile or bypass).
- REQ-012: load_use_stall  output  1  OR of ~src_ready for sources of valid issuing lanes.

Function
- REQ-013: 32 entries, one per architectural register; each entry holds valid, position[2:0] (one-hot or zero), line, is_load.
- REQ-014: position encoding: 100 = producer in execute, 010 = memory, 001 = commit, 000 = value in register file.
- REQ-015: Entry 0 SHALL never be written; lookups of register 0 SHALL return position 000, line 0, ready 1.
- REQ-016: Lookup is combinational on registered state; issues in the same cycle do not affect that cycle's outputs.
- REQ-017: Intra-pair dependences (lane1 source = lane0 dest) are not detected here; the issue unit prevents them.
- REQ-018: On a rising edge with advance=1, each valid entry SHALL shift its position right one place: 100->010->001->000. An entry reaching 000 becomes invalid.
- REQ-019: On a rising edge with advance=1 and issue_valid[i]=1 and issue_dest[i]!=0, entry issue_dest[i] SHALL be overwritten with position 100, line i, is_load issue_is_load[i]. The overwrite takes priority over the shift.
- REQ-020: If both lanes issue to the same dest, lane 1 (younger) SHALL win.
- REQ-021: With advance=0, all entries SHALL hold and issue_valid SHALL be ignored.
- REQ-022: flush=1 on a rising edge SHALL invalidate all entries (position 000), regardless of advance and issue. Commit-stage producers finish their writeback in that same cycle.
- REQ-023: src_ready[k] SHALL be 0 only when the entry is valid, position=100 and is_load=1. Otherwise it is 1.
- REQ-024: score_board_data[k].position SHALL equal the entry position (000 if invalid), and .line the stored line.
- REQ-025: load_use_stall = (issue_valid[0] & ~(src_ready[0] & src_ready[1])) | (issue_valid[1] & ~(src_ready[2] & src_ready[3])).
- REQ-026: The upstream controller SHALL drive advance=0 whenever load_use_stall=1. The block itself does not gate advance.

Reset
- REQ-027: While resetn=0, all entries SHALL be invalid, position 000, line 0, is_load 0, asynchronously.
- REQ-028: After reset, all src_ready = 1, all score_board_data = 0, and load_use_stall = 0 (given issue_valid = 0).
- REQ-029: Deassertion of reset mid-stream SHALL start from the empty state. No prior in-flight state survives.

Verification
- REQ-030: Basic pipeline walk:
  - Stimulus: issue lane0 dest 5 (non-load), advance=1, then query src 5 each cycle.
  - Response: position 100/line 0, then 010, then 001, then 000 over four cycles.
- REQ-031: Same-cycle same-destination issue:
  - Stimulus: both lanes issue dest 7.
  - Response: next cycle, src 7 gives position 100, line 1.
- REQ-032: Overwrite of an older producer:
  - Stimulus: issue dest 3, advance one cycle, then issue dest 3 again.
  - Response: src 3 gives 100 (newest producer), not 010.
- REQ-033: Load-use stall and release:
  - Stimulus: issue load lane1 dest 9; next cycle lane0 issues with rs=9.
  - Response: src_ready[0]=0 and load_use_stall=1.
  - With advance=0 held one cycle, the state is unchanged.
  - After one advance, position is 010 and ready=1.
- REQ-034: Flush and register 0:
  - Stimulus: flush with entries at 100/010/001.
  - Response: all lookups 000, ready=1 next cycle.
  - Issue to dest 0 leaves entry 0 untouched.
- REQ-035: Asynchronous reset:
  - Stimulus: assert resetn=0 mid-cycle with entries valid.
  - Response: outputs go to zero before the next clock edge.
